// File: rtl/spis_pkg.sv
// Shared definitions for the SPIS UART transmitter: register map, STATUS layout, FSM encoding.
package spis_pkg;

    localparam logic [11:0] UART_BASE_ADDR = 12'hFF0;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_RSV2   = 2'd2;
    localparam logic [1:0] OFF_RSV3   = 2'd3;

    localparam int unsigned ST_BUSY   = 0;
    localparam int unsigned ST_FULL   = 1;
    localparam int unsigned ST_EMPTY  = 2;
    localparam int unsigned ST_OVF    = 3;
    localparam int unsigned ST_CNT_LO = 4;
    localparam int unsigned ST_CNT_HI = 5;
    localparam int unsigned ST_CNT4   = 6;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // Count bits hold count mod 4; bit 6 disambiguates a full FIFO from an empty one.
    function automatic logic [7:0] pack_status(input logic busy, input logic full,
                                               input logic empty, input logic ovf,
                                               input logic [CNT_W-1:0] count);
        logic [7:0] s;
        s                      = 8'h00;
        s[ST_BUSY]             = busy;
        s[ST_FULL]             = full;
        s[ST_EMPTY]            = empty;
        s[ST_OVF]              = ovf;
        s[ST_CNT_HI:ST_CNT_LO] = count[1:0];
        s[ST_CNT4]             = (count == 3'd4);
        return s;
    endfunction

endpackage

// File: rtl/spis_fifo4.sv
// Four-entry circular byte FIFO feeding the UART transmitter.
module spis_fifo4
    import spis_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c,
    output logic              full_c,
    output logic              empty_c,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full_c  = (count == CNT_W'(FIFO_DEPTH));
    assign empty_c = (count == '0);
    assign rdata_c = mem[rd_ptr];

    // Full is judged before the edge, so a push into a full FIFO is dropped even alongside a pop.
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !reset) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/spis_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, baud timing and frame FSM around a 4-byte FIFO.
module spis_uart_tx
    import spis_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter logic [11:0] BASE_ADDR    = UART_BASE_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [7:0]  dataBus,
    input  logic [11:0] addressBus,
    input  logic        write,
    input  logic        sync,
    output logic        txd,
    output logic        irq
);

    tx_state_t         state;
    logic [7:0]        baud;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              overflow;

    logic              hit_c;
    logic [1:0]        offset_c;
    logic              wr_txdata_c;
    logic              wr_status_c;
    logic              baud_last_c;
    logic              pop_c;
    logic [7:0]        rd_data_c;

    logic [DATA_W-1:0] fifo_rdata_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic [CNT_W-1:0]  fifo_count;

    logic              unused_sync;
    assign unused_sync = sync;

    assign hit_c       = (addressBus[11:2] == BASE_ADDR[11:2]);
    assign offset_c    = addressBus[1:0];
    assign wr_txdata_c = write && hit_c && (offset_c == OFF_TXDATA);
    assign wr_status_c = write && hit_c && (offset_c == OFF_STATUS);
    assign baud_last_c = (baud == 8'(CLKS_PER_BIT - 1));

    // Head byte leaves the FIFO on the edge that enters START, from IDLE or from the end of STOP.
    assign pop_c = !fifo_empty_c &&
                   ((state == S_IDLE) || ((state == S_STOP) && baud_last_c));

    spis_fifo4 u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (wr_txdata_c),
        .pop     (pop_c),
        .wdata   (dataBus),
        .rdata_c (fifo_rdata_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .count   (fifo_count)
    );

    always_comb begin
        rd_data_c = 8'h00;
        case (offset_c)
            OFF_STATUS: rd_data_c = pack_status(state != S_IDLE, fifo_full_c, fifo_empty_c,
                                                overflow, fifo_count);
            default:    rd_data_c = 8'h00;
        endcase
    end

    assign dataBus = (hit_c && !write) ? rd_data_c : 8'bzzzz_zzzz;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_txdata_c && fifo_full_c) begin
            overflow <= 1'b1;
        end else if (wr_status_c) begin
            overflow <= 1'b0;
        end
    end

    // txd follows the state one cycle late, giving the 2-clock write-to-start latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            baud    <= 8'd0;
            bit_idx <= 3'd0;
            shreg   <= '0;
            txd     <= 1'b1;
            irq     <= 1'b1;
        end else begin
            irq <= fifo_empty_c && (state == S_IDLE);
            case (state)
                S_IDLE: begin
                    txd  <= 1'b1;
                    baud <= 8'd0;
                    if (!fifo_empty_c) begin
                        state <= S_START;
                        shreg <= fifo_rdata_c;
                    end
                end
                S_START: begin
                    txd <= 1'b0;
                    if (baud_last_c) begin
                        state   <= S_DATA;
                        baud    <= 8'd0;
                        bit_idx <= 3'd0;
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                S_DATA: begin
                    txd <= shreg[bit_idx];
                    if (baud_last_c) begin
                        baud <= 8'd0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                S_STOP: begin
                    txd <= 1'b1;
                    if (baud_last_c) begin
                        baud <= 8'd0;
                        if (!fifo_empty_c) begin
                            state <= S_START;
                            shreg <= fifo_rdata_c;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    baud  <= 8'd0;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/spis_uart_tx.md
SPIS_UART_TX -- requirements
Module: spis_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..255.
REQ-002 Parameter BASE_ADDR, default 12'hFF0, base of the 4-byte register window.
REQ-003 clock  input  1  system clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 dataBus  inout  8  shared CPU/memory data bus.
REQ-006 addressBus  input  12  CPU address.
REQ-007 write  input  1  CPU write strobe, high = write cycle.
REQ-008 sync  input  1  CPU fetch indicator; ignored by this block.
REQ-009 txd  output  1  serial output, 8N1, idle high.
REQ-010 irq  output  1  high while FIFO empty and transmitter idle.

Function
REQ-011 Window decode: hit = addressBus[11:2] == BASE_ADDR[11:2]; offset = addressBus[1:0].
REQ-012 Offset 0 TXDATA: a write on a clock edge with write=1 and hit pushes dataBus into the FIFO; a read returns 8'h00.
REQ-013 Offset 1 STATUS read: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow, bits5:4 FIFO count mod 4, bit6 = count==4, bit7 0.
REQ-014 A STATUS write, with any data, clears overflow on that edge.
REQ-015 Offsets 2 and 3 read 8'h00; writes to them are ignored.
REQ-016 dataBus is driven combinationally only when hit=1 and write=0; otherwise it is high-Z.
REQ-017 FIFO: 4 entries x 8 bits, circular, with 2-bit read/write pointers and a 3-bit count.
REQ-018 A push while full (evaluated before the edge) is dropped and sets overflow, even if a pop occurs on the same edge.
REQ-019 Simultaneous push and pop when not full: both take effect and count is unchanged.
REQ-020 FSM states: IDLE, START, DATA, STOP.
REQ-021 IDLE->START: on the first edge where FIFO is non-empty; the head byte is popped into the shift register on that same edge.
REQ-022 START: txd=0 for CLKS_PER_BIT cycles, then DATA.
REQ-023 DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, tracked by a 3-bit bit index; after bit 7, go to STOP.
REQ-024 STOP: txd=1 for CLKS_PER_BIT cycles, then START if FIFO is non-empty (pop on that edge), else IDLE.
REQ-025 Back-to-back frames have no idle gap beyond the stop bit.
REQ-026 The baud counter is 8-bit, counts 0..CLKS_PER_BIT-1, and reloads 0 on every state change.
REQ-027 txd is registered; latency from the TXDATA write edge (FIFO empty, IDLE) to the txd falling edge is 2 clocks.
REQ-028 irq = empty AND state==IDLE, registered.

Reset
REQ-029 Reset asserted asynchronously forces: txd=1, irq=1, state IDLE, FIFO pointers/count 0, overflow 0, baud counter 0, bit index 0, shift register 0.
REQ-030 Reset mid-frame aborts the frame immediately; txd returns high with no partial stop bit.
REQ-031 Bus writes during reset are discarded; dataBus tri-state behaviour follows REQ-016 regardless of reset.

Structure
REQ-032 Shared package spis_pkg holds UART_BASE_ADDR, the register offsets, the STATUS bit positions, and the FSM state encoding.
REQ-033 The FIFO is a separate sub-module, spis_fifo4, with push/pop/data/full/empty/count ports; the FSM, decode and baud logic stay in spis_uart_tx.
REQ-034 The block sits on the existing cpu/memory bus; the top level excludes 12'hFF0-12'hFF3 from memory's read drive.

Verification
REQ-035 Reset, then write 8'hA5 to 12'hFF0 (CLKS_PER_BIT=4) -> txd low 2 clocks later; bits 1,0,1,0,0,1,0,1, 4 clocks each; stop high 4 clocks; irq back to 1.
REQ-036 Five writes 8'h01..8'h05 within 5 cycles while IDLE -> the first is popped immediately; all five are sent in order, no overflow, 40 cycles/frame, no gaps.
REQ-037 Fill FIFO while a frame is in progress, then write 8'hFF -> STATUS reads bit1=1, bit3=1; 8'hFF is never transmitted; a STATUS write clears bit3.
REQ-038 Assert reset during DATA bit 3 of 8'h3C -> txd=1 within the same cycle; STATUS reads 8'h04 after release; no further output.
REQ-039 Read 12'hFF2 -> 8'h00 driven; read 12'hFEF -> dataBus high-Z from this block; a write to 12'hFEF does not alter the FIFO.
REQ-040 Push on the same edge as a STOP->START pop with count=2 -> count stays 2 and byte order is preserved.
